// File: rtl/iob_ethoc_sim_wrapper.sv
// Ethernet MAC sim model on an IOb slave: mode/IRQ regs, one TX/RX BD, 1 KiB packet RAM, loopback copy engine.
// Every request is accepted and answered exactly one cycle later (no backpressure); the engine yields RAM to the bus.
module iob_ethoc_sim_wrapper #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                eth_clk_i,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready
);
    localparam int NB = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    logic [DATA_W-1:0] mem [0:255];

    state_t            state_q, state_d;
    logic [16:0]       moder_q, moder_d;
    logic              txb_q, txb_d, rxb_q, rxb_d, busy_q, busy_d;
    logic [6:0]        mask_q, mask_d;
    logic [DATA_W-1:0] txc_q, txc_d, txp_q, txp_d, rxc_q, rxc_d, rxp_q, rxp_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        src_q, src_d, dst_q, dst_d;
    logic [14:0]       left_q, left_d;
    logic              loop_q, loop_d, pend_q, pend_d;
    logic [2:0]        sync_q;
    logic [DATA_W-1:0] rdata_q, rdata_d, rd_val;
    logic              ready_q, ready_d;

    logic [9:0]  wa;
    logic        hi_zero, unused_addr;
    logic        sel_moder, sel_int, sel_mask, sel_txc, sel_txp, sel_rxc, sel_rxp, sel_ram;
    logic        bus_wr, bus_rd, bus_ram, tick, go, eng_wr;
    logic [14:0] words;

    assign wa          = address[11:2];
    assign unused_addr = ^address[1:0];
    assign hi_zero     = (address >> 12) == '0;
    assign sel_moder   = hi_zero && (wa == 10'h000);
    assign sel_int     = hi_zero && (wa == 10'h001);
    assign sel_mask    = hi_zero && (wa == 10'h002);
    assign sel_txc     = hi_zero && (wa == 10'h100);
    assign sel_txp     = hi_zero && (wa == 10'h101);
    assign sel_rxc     = hi_zero && (wa == 10'h180);
    assign sel_rxp     = hi_zero && (wa == 10'h181);
    assign sel_ram     = hi_zero && (wa[9:8] == 2'b10);

    assign bus_wr  = valid && (|wstrb);
    assign bus_rd  = valid && !(|wstrb);
    assign bus_ram = valid && sel_ram;

    // eth_clk_i is sampled as data; a rising edge becomes a one-cycle tick
    assign tick   = sync_q[1] && !sync_q[2];
    assign go     = tick || pend_q;
    assign eng_wr = (state_q == XFER) && (left_q != 15'd0) && go && !bus_ram && loop_q;
    assign words  = {1'b0, txc_q[31:18]} + {14'd0, |txc_q[17:16]};

    assign rdata = rdata_q;
    assign ready = ready_q;

    always_comb begin
        rd_val = '0;
        if (sel_moder) rd_val = DATA_W'(moder_q);
        if (sel_int)   rd_val = DATA_W'({busy_q, 1'b0, rxb_q, 1'b0, txb_q});
        if (sel_mask)  rd_val = DATA_W'(mask_q);
        if (sel_txc)   rd_val = txc_q;
        if (sel_txp)   rd_val = txp_q;
        if (sel_rxc)   rd_val = rxc_q;
        if (sel_rxp)   rd_val = rxp_q;
        if (sel_ram)   rd_val = mem[wa[7:0]];
        ready_d = valid;
        rdata_d = bus_rd ? rd_val : '0;
    end

    always_comb begin
        state_d = state_q;
        moder_d = moder_q;
        txb_d   = txb_q;
        rxb_d   = rxb_q;
        busy_d  = busy_q;
        mask_d  = mask_q;
        txc_d   = txc_q;
        txp_d   = txp_q;
        rxc_d   = rxc_q;
        rxp_d   = rxp_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        left_d  = left_q;
        loop_d  = loop_q;
        pend_d  = 1'b0;

        if (bus_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    if (sel_txc) txc_d[8*b +: 8] = wdata[8*b +: 8];
                    if (sel_txp) txp_d[8*b +: 8] = wdata[8*b +: 8];
                    if (sel_rxc) rxc_d[8*b +: 8] = wdata[8*b +: 8];
                    if (sel_rxp) rxp_d[8*b +: 8] = wdata[8*b +: 8];
                end
            end
            if (sel_moder) begin
                if (wstrb[0]) moder_d[7:0]  = wdata[7:0];
                if (wstrb[1]) moder_d[15:8] = wdata[15:8];
                if (wstrb[2]) moder_d[16]   = wdata[16];
            end
            if (sel_mask && wstrb[0]) mask_d = wdata[6:0];
            if (sel_int && wstrb[0]) begin
                if (wdata[0]) txb_d  = 1'b0;
                if (wdata[2]) rxb_d  = 1'b0;
                if (wdata[4]) busy_d = 1'b0;
            end
        end

        // engine updates come after bus writes so they win on a same-cycle collision
        case (state_q)
            IDLE: begin
                if (moder_q[1] && txc_q[15]) begin
                    state_d = XFER;
                    len_d   = txc_q[31:16];
                    src_d   = txp_q[9:2];
                    dst_d   = rxp_q[9:2];
                    left_d  = words;
                    loop_d  = moder_q[7] && moder_q[0] && rxc_q[15];
                    if (moder_q[7] && !(moder_q[0] && rxc_q[15])) busy_d = 1'b1;
                end
            end
            XFER: begin
                if (left_q == 15'd0) begin
                    if (tick) state_d = DONE;
                end else if (go) begin
                    if (bus_ram) begin
                        pend_d = 1'b1;
                    end else begin
                        src_d  = src_q + 8'd1;
                        dst_d  = dst_q + 8'd1;
                        left_d = left_q - 15'd1;
                        if (left_q == 15'd1) state_d = DONE;
                    end
                end
            end
            DONE: begin
                txc_d[15] = 1'b0;
                txb_d     = 1'b1;
                if (loop_q) begin
                    rxc_d[15]    = 1'b0;
                    rxc_d[31:16] = len_q;
                    rxb_d        = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            moder_q <= 17'h0A000;
            txb_q   <= 1'b0;
            rxb_q   <= 1'b0;
            busy_q  <= 1'b0;
            mask_q  <= '0;
            txc_q   <= '0;
            txp_q   <= '0;
            rxc_q   <= '0;
            rxp_q   <= '0;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            left_q  <= '0;
            loop_q  <= 1'b0;
            pend_q  <= 1'b0;
            sync_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            moder_q <= moder_d;
            txb_q   <= txb_d;
            rxb_q   <= rxb_d;
            busy_q  <= busy_d;
            mask_q  <= mask_d;
            txc_q   <= txc_d;
            txp_q   <= txp_d;
            rxc_q   <= rxc_d;
            rxp_q   <= rxp_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            left_q  <= left_d;
            loop_q  <= loop_d;
            pend_q  <= pend_d;
            sync_q  <= {sync_q[1:0], eth_clk_i};
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arst_i) begin
            if (bus_ram) begin
                for (int b = 0; b < NB; b++) begin
                    if (wstrb[b]) mem[wa[7:0]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else if (eng_wr) begin
                mem[dst_q] <= mem[src_q];
            end
        end
    end

endmodule

// File: tb/tb_iob_ethoc_sim_wrapper.sv
// Bench for iob_ethoc_sim_wrapper: register table, randomized RAM/register traffic against a byte-level model,
// and hand-written loopback, busy, zero-length and mid-transfer reset sequences.
module tb_iob_ethoc_sim_wrapper;
    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        eth_clk = 1'b0;
    logic        valid = 1'b0;
    logic [11:0] address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [16];
    logic [7:0]  m_ram [1024];
    logic [31:0] m_reg [4];
    logic [11:0] reg_addr [4];

    iob_ethoc_sim_wrapper #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk_i    (clk),
        .arst_i   (arst),
        .eth_clk_i(eth_clk),
        .valid    (valid),
        .address  (address),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .rdata    (rdata),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one bus transaction; response (ready and rdata) is checked one cycle after the request
    task automatic xact(input string name, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp);
        @(posedge clk); #1;
        valid = 1'b1; address = a; wdata = d; wstrb = s;
        @(posedge clk); #1;
        valid = 1'b0; wstrb = '0;
        check(name, {ready, rdata}, {1'b1, exp});
    endtask

    task automatic eth_tick();
        @(posedge clk); #1;
        eth_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1 eth_clk = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic loop_setup(input logic [31:0] rxc);
        xact("src0", 12'h800, 32'h11111111, 4'hF, 32'h0);
        xact("src1", 12'h804, 32'h22222222, 4'hF, 32'h0);
        xact("src2", 12'h808, 32'h33333333, 4'hF, 32'h0);
        xact("src3", 12'h80C, 32'h44444444, 4'hF, 32'h0);
        xact("rxptr_w", 12'h604, 32'h00000080, 4'hF, 32'h0);
        xact("rxctl_w", 12'h600, rxc, 4'hF, 32'h0);
        xact("moder_lb", 12'h000, 32'h0000A481, 4'hF, 32'h0);
        xact("txptr_w", 12'h404, 32'h0, 4'hF, 32'h0);
        xact("txctl_w", 12'h400, 32'h00109000, 4'hF, 32'h0);
        xact("moder_go", 12'h000, 32'h0000A483, 4'hF, 32'h0);
    endtask

    task automatic fill_dest();
        for (int k = 0; k < 4; k++)
            xact("dst_fill", 12'(12'h880 + k * 4), 32'hDEAD0000 + 32'(k), 4'hF, 32'h0);
    endtask

    initial begin
        int          kind, idx, r;
        logic [31:0] v, e;
        logic [3:0]  s;
        logic [11:0] a;

        tbl[0]  = '{12'h000, 32'h0000A080, 4'hF, 32'h0};
        tbl[1]  = '{12'h000, 32'h0000A480, 4'hF, 32'h0};
        tbl[2]  = '{12'h000, 32'h0,        4'h0, 32'h0000A480};
        tbl[3]  = '{12'h008, 32'hFFFFFFFF, 4'h1, 32'h0};
        tbl[4]  = '{12'h008, 32'h0,        4'h0, 32'h0000007F};
        tbl[5]  = '{12'h000, 32'hFFFFFFFF, 4'h4, 32'h0};
        tbl[6]  = '{12'h000, 32'h0,        4'h0, 32'h0001A480};
        tbl[7]  = '{12'h000, 32'h0000A480, 4'hF, 32'h0};
        tbl[8]  = '{12'h404, 32'h12345678, 4'h5, 32'h0};
        tbl[9]  = '{12'h404, 32'h0,        4'h0, 32'h00340078};
        tbl[10] = '{12'h00C, 32'hDEADBEEF, 4'hF, 32'h0};
        tbl[11] = '{12'h00C, 32'h0,        4'h0, 32'h0};
        tbl[12] = '{12'h300, 32'h0,        4'h0, 32'h0};
        tbl[13] = '{12'h700, 32'h0,        4'h0, 32'h0};
        tbl[14] = '{12'h008, 32'h00000000, 4'hE, 32'h0};
        tbl[15] = '{12'h008, 32'h0,        4'h0, 32'h0000007F};

        repeat (3) @(posedge clk);
        #1 check("reset_outputs", {ready, rdata}, 33'h0);
        arst = 1'b0;

        // first read: ready must be low at request, high exactly one cycle later, then low again
        @(posedge clk); #1;
        valid = 1'b1; address = 12'h000; wstrb = 4'h0;
        check("ready_low_at_req", {32'h0, ready}, 33'h0);
        @(posedge clk); #1;
        valid = 1'b0;
        check("reset_moder_read", {ready, rdata}, {1'b1, 32'h0000A000});
        @(posedge clk); #1;
        check("ready_single_pulse", {32'h0, ready}, 33'h0);

        for (int i = 0; i < 16; i++)
            xact($sformatf("tbl%0d", i), tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].exp);

        // randomized traffic against a byte-addressed model
        reg_addr[0] = 12'h008; reg_addr[1] = 12'h404; reg_addr[2] = 12'h600; reg_addr[3] = 12'h604;
        m_reg[0] = 32'h7F; m_reg[1] = 32'h00340078; m_reg[2] = 32'h0; m_reg[3] = 32'h0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            xact("ram_init", 12'(12'h800 + i * 4), v, 4'hF, 32'h0);
            for (int b = 0; b < 4; b++) m_ram[i*4+b] = v[8*b +: 8];
        end
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 3);
            idx  = $urandom_range(0, 255);
            v    = $urandom;
            s    = 4'($urandom_range(1, 15));
            case (kind)
                0: begin
                    xact("rnd_ram_wr", 12'(12'h800 + idx * 4), v, s, 32'h0);
                    for (int b = 0; b < 4; b++) if (s[b]) m_ram[idx*4+b] = v[8*b +: 8];
                end
                1: begin
                    e = {m_ram[idx*4+3], m_ram[idx*4+2], m_ram[idx*4+1], m_ram[idx*4]};
                    xact($sformatf("rnd_ram_rd@%0h", idx * 4), 12'(12'h800 + idx * 4), 32'h0, 4'h0, e);
                end
                2: begin
                    r = $urandom_range(0, 3);
                    if ($urandom_range(0, 1) == 1) begin
                        xact("rnd_reg_wr", reg_addr[r], v, s, 32'h0);
                        for (int b = 0; b < 4; b++) if (s[b]) m_reg[r][8*b +: 8] = v[8*b +: 8];
                        if (r == 0) m_reg[0] = m_reg[0] & 32'h7F;
                    end else begin
                        xact($sformatf("rnd_reg_rd@%0h", reg_addr[r]), reg_addr[r], 32'h0, 4'h0, m_reg[r]);
                    end
                end
                default: begin
                    a = 12'(12'h00C + ($urandom_range(0, 252) * 4));
                    xact($sformatf("rnd_unmapped@%0h", a), a, 32'h0, 4'h0, 32'h0);
                end
            endcase
        end

        // loopback of four words
        xact("int_clr0", 12'h004, 32'h1F, 4'hF, 32'h0);
        loop_setup(32'h00108000);
        repeat (4) eth_tick();
        repeat (2) @(posedge clk);
        xact("lb_dst0", 12'h880, 32'h0, 4'h0, 32'h11111111);
        xact("lb_dst1", 12'h884, 32'h0, 4'h0, 32'h22222222);
        xact("lb_dst2", 12'h888, 32'h0, 4'h0, 32'h33333333);
        xact("lb_dst3", 12'h88C, 32'h0, 4'h0, 32'h44444444);
        xact("lb_txctl", 12'h400, 32'h0, 4'h0, 32'h00101000);
        xact("lb_rxctl", 12'h600, 32'h0, 4'h0, 32'h00100000);
        xact("lb_int", 12'h004, 32'h0, 4'h0, 32'h00000005);

        // loopback requested but RX BD not empty: BUSY, no copy
        fill_dest();
        xact("int_clr1", 12'h004, 32'h1F, 4'hF, 32'h0);
        xact("int_clr1_rd", 12'h004, 32'h0, 4'h0, 32'h0);
        loop_setup(32'h0);
        repeat (4) eth_tick();
        repeat (2) @(posedge clk);
        xact("busy_int", 12'h004, 32'h0, 4'h0, 32'h00000011);
        xact("busy_txctl", 12'h400, 32'h0, 4'h0, 32'h00101000);
        xact("busy_rxctl", 12'h600, 32'h0, 4'h0, 32'h0);
        xact("busy_dst0", 12'h880, 32'h0, 4'h0, 32'hDEAD0000);

        // zero-length TX without loopback
        xact("int_clr2", 12'h004, 32'h1F, 4'hF, 32'h0);
        xact("z_rxctl_w", 12'h600, 32'h00208000, 4'hF, 32'h0);
        xact("z_moder_off", 12'h000, 32'h0000A000, 4'hF, 32'h0);
        xact("z_txctl_w", 12'h400, 32'h00008000, 4'hF, 32'h0);
        xact("z_moder_go", 12'h000, 32'h0000A002, 4'hF, 32'h0);
        xact("z_int_before_tick", 12'h004, 32'h0, 4'h0, 32'h0);
        eth_tick();
        repeat (2) @(posedge clk);
        xact("z_int_after_tick", 12'h004, 32'h0, 4'h0, 32'h00000001);
        xact("z_rxctl", 12'h600, 32'h0, 4'h0, 32'h00208000);
        xact("z_txctl", 12'h400, 32'h0, 4'h0, 32'h0);
        xact("z_w1c", 12'h004, 32'h1, 4'hF, 32'h0);
        xact("z_int_cleared", 12'h004, 32'h0, 4'h0, 32'h0);

        // reset after two of four words have been copied
        fill_dest();
        loop_setup(32'h00108000);
        repeat (2) eth_tick();
        @(posedge clk); #1 arst = 1'b1;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        repeat (2) eth_tick();
        repeat (2) @(posedge clk);
        xact("rst_moder", 12'h000, 32'h0, 4'h0, 32'h0000A000);
        xact("rst_int", 12'h004, 32'h0, 4'h0, 32'h0);
        xact("rst_mask", 12'h008, 32'h0, 4'h0, 32'h0);
        xact("rst_txctl", 12'h400, 32'h0, 4'h0, 32'h0);
        xact("rst_txptr", 12'h404, 32'h0, 4'h0, 32'h0);
        xact("rst_rxctl", 12'h600, 32'h0, 4'h0, 32'h0);
        xact("rst_rxptr", 12'h604, 32'h0, 4'h0, 32'h0);
        xact("rst_dst0", 12'h880, 32'h0, 4'h0, 32'h11111111);
        xact("rst_dst1", 12'h884, 32'h0, 4'h0, 32'h22222222);
        xact("rst_dst2", 12'h888, 32'h0, 4'h0, 32'hDEAD0002);
        xact("rst_dst3", 12'h88C, 32'h0, 4'h0, 32'hDEAD0003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/iob_ethoc_sim_wrapper.md
Name: iob_ethoc_sim_wrapper

Overview:
Simulation-scale model of an OpenCores-style Ethernet MAC behind an IOb native slave bus.
- Holds the MAC mode/interrupt registers, one TX and one RX buffer descriptor (BD), and a 1 KiB packet buffer RAM.
- Contains a loopback engine that copies a TX frame into the RX buffer.
- Used as the self-contained DUT for bench bring-up of the ethernet software flow.

Parameters:
- ADDR_W, 12, bus byte-address width (minimum 12).
- DATA_W, 32, bus data width (fixed at 32).

Ports:
- clk_i  in  1  system clock; the only clock.
- arst_i  in  1  reset, synchronous to clk_i, active-high.
- eth_clk_i  in  1  ethernet line clock. Treated as data: synchronized by 2 flops, rising-edge detected into a one-cycle "tick".
- valid  in  1  request strobe.
- address  in  ADDR_W  byte address; bits [1:0] ignored.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte enables; nonzero = write, zero = read.
- rdata  out  DATA_W  read data, valid while ready=1.
- ready  out  1  one-cycle response pulse.

Behaviour:
Reset and bus protocol
- Reset: ready=0, rdata=0, registers to reset values, engine IDLE. RAM contents are not reset.
- Every valid=1 cycle is accepted. ready pulses exactly 1 cycle later; rdata is registered at the same time.
- Writes apply per-byte under wstrb. Write responses return rdata=0.
- Unmapped reads return 0; unmapped writes are ignored.

Address map
- 0x000 MODER: 17 bits stored, upper bits read 0, reset 0x0000A000. Bits: 0 RXEN, 1 TXEN, 7 LOOPBCK, 10 FULLD, 13 CRCEN, 15 PAD.
- 0x004 INT_SOURCE: bit0 TXB, bit2 RXB, bit4 BUSY. Write-1-to-clear. Reset 0.
- 0x008 INT_MASK: bits[6:0] R/W, reset 0. Storage only; there is no IRQ port.
- 0x400 TX_BD0 ctrl: [31:16] LEN (bytes), bit15 RD, others R/W storage. Reset 0.
- 0x404 TX_BD0 ptr: byte offset into RAM, reset 0.
- 0x600 RX_BD0 ctrl: [31:16] LEN, bit15 E (empty), others R/W storage. Reset 0.
- 0x604 RX_BD0 ptr: byte offset into RAM, reset 0.
- 0x800-0xBFF: packet RAM, 256x32, byte-writable, readable over the bus. Pointers use bits [9:2] and wrap modulo 1 KiB.

Engine states: IDLE, XFER, DONE
- IDLE -> XFER when TXEN=1 and TX RD=1.
  - Latch LEN, both pointers, and mode: LOOP = LOOPBCK & RXEN & RX E.
  - If LOOPBCK=1 but RXEN=0 or E=0, set BUSY at start and do not loop back.
- XFER moves one word per tick, ceil(LEN/4) words total.
  - If LOOP, copy RAM[txptr+4k] to RAM[rxptr+4k]; otherwise the word is discarded.
  - Bus RAM access has priority: the engine stalls that cycle and retries.
- LEN=0: no words moved; go to DONE on the next tick.
- DONE, one cycle:
  - Clear TX RD and set TXB.
  - If LOOP: clear RX E, write RX LEN = TX LEN, set RXB.
  - Return to IDLE.
- Later BD or MODER writes do not affect an active transfer. Clearing TXEN mid-XFER does not abort.
- A bus write that sets an interrupt bit in the same cycle the engine sets it: the set wins. A bus write to RD/E in the DONE cycle: the engine's update wins.
- Reset mid-transfer: engine returns to IDLE immediately; no further RAM writes.

Test Plan:
- Release reset, read 0x000 -> ready exactly 1 cycle after valid, rdata=0x0000A000.
- Write 0x000=0x0000A080 then 0x0000A480 (wstrb=0xF), read 0x000 -> 0x0000A480. Write 0x008=0xFFFFFFFF with wstrb=0x1 -> reads 0x0000007F.
- Loopback:
  - Setup: load 0x11111111/0x22222222/0x33333333/0x44444444 at 0x800-0x80C. Write 0x604=0x80, 0x600=0x00108000, MODER=0xA481, 0x404=0, 0x400=0x00109000, MODER=0xA483.
  - Expected after 4 ticks + 2 cycles: 0x880-0x88C equal the source words; 0x400=0x00101000; 0x600=0x00100000; INT_SOURCE=0x5.
- Same setup but 0x600=0 -> INT_SOURCE=0x11, TX RD cleared, RAM at 0x880 unchanged.
- TX with LOOPBCK=0 and LEN=0 -> TXB set after 1 tick, RX BD unchanged. Write 0x004=0x1 -> reads 0.
- Assert arst_i mid-XFER -> all registers at reset values, destination words not yet copied remain unwritten.
